firebird7_in_gate1_tessent_data_mux_seq: RTL



---
 rtl/firebird7_in_gate1_tessent_data_mux_seq_if.sv | 31 +++
 rtl/firebird7_in_gate1_tessent_data_mux_seq.sv | 97 +++++++++
 2 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_seq_if.sv
// Bus bundle for the gate1 registered IJTAG/functional data mux.
// Channel c of every packed data field occupies bits [c*WIDTH +: WIDTH].
interface firebird7_in_gate1_tessent_data_mux_seq_if #(
  parameter int unsigned WIDTH    = 19,
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0]       ijtag_select;
  logic [CHANNELS*WIDTH-1:0] functional_data_in;
  logic [CHANNELS*WIDTH-1:0] ijtag_data_in;
  logic [CHANNELS*WIDTH-1:0] data_out;
  logic [CHANNELS-1:0]       ijtag_active;
  logic                      switch_busy;

  modport master (
    output ijtag_select,
    output functional_data_in,
    output ijtag_data_in,
    input  data_out,
    input  ijtag_active,
    input  switch_busy
  );

  modport slave (
    input  ijtag_select,
    input  functional_data_in,
    input  ijtag_data_in,
    output data_out,
    output ijtag_active,
    output switch_busy
  );
endinterface

// File: rtl/firebird7_in_gate1_tessent_data_mux_seq.sv
// Multi-channel registered IJTAG/functional data mux. Each lane passes through a frozen
// hold phase of SETTLE cycles when its source changes, so no same-cycle source swap is seen.
module firebird7_in_gate1_tessent_data_mux_seq #(
  parameter int unsigned WIDTH    = 19,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SETTLE   = 2
) (
  input logic ijtag_tck,
  input logic ijtag_reset,
  firebird7_in_gate1_tessent_data_mux_seq_if.slave bus
);

  localparam int unsigned CntW = (SETTLE + 1 > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE - 1);

  typedef enum logic [1:0] {
    StFunc,
    StHoldI,
    StIjtag,
    StHoldF
  } state_e;

  state_e           state_q [CHANNELS];
  logic [CntW-1:0]  cnt_q   [CHANNELS];
  logic [WIDTH-1:0] data_q  [CHANNELS];

  // Per-lane FSM; select is ignored while holding, so a late request change is seen
  // on the first edge after the target state is entered.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= StFunc;
        cnt_q[c]   <= '0;
        data_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        unique case (state_q[c])
          StFunc: begin
            if (bus.ijtag_select[c]) begin
              state_q[c] <= StHoldI;
              cnt_q[c]   <= CntLoad;
            end else begin
              data_q[c] <= bus.functional_data_in[c*WIDTH +: WIDTH];
            end
          end
          StHoldI: begin
            if (cnt_q[c] == '0) begin
              state_q[c] <= StIjtag;
            end else begin
              cnt_q[c] <= cnt_q[c] - CntW'(1);
            end
          end
          StIjtag: begin
            if (!bus.ijtag_select[c]) begin
              state_q[c] <= StHoldF;
              cnt_q[c]   <= CntLoad;
            end else begin
              data_q[c] <= bus.ijtag_data_in[c*WIDTH +: WIDTH];
            end
          end
          StHoldF: begin
            if (cnt_q[c] == '0) begin
              state_q[c] <= StFunc;
            end else begin
              cnt_q[c] <= cnt_q[c] - CntW'(1);
            end
          end
          default: begin
            state_q[c] <= StFunc;
            cnt_q[c]   <= '0;
          end
        endcase
      end
    end
  end

  logic [CHANNELS*WIDTH-1:0] data_flat;
  logic [CHANNELS-1:0]       active_flat;
  logic [CHANNELS-1:0]       busy_flat;

  always_comb begin
    data_flat   = '0;
    active_flat = '0;
    busy_flat   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      data_flat[c*WIDTH +: WIDTH] = data_q[c];
      active_flat[c]              = (state_q[c] == StIjtag);
      busy_flat[c]                = (state_q[c] == StHoldI) || (state_q[c] == StHoldF);
    end
  end

  assign bus.data_out     = data_flat;
  assign bus.ijtag_active = active_flat;
  assign bus.switch_busy  = |busy_flat;

endmodule
